// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//
// Time-multiplexed scan controller for a four-digit 7-segment display.
// Each digit is driven for SCAN_DIV clocks, followed by an optional
// BLANK_CYC-clock gap with every digit off. New display data is double
// buffered: a load fills the pending buffer, and the pending buffer moves to
// the active buffer only at a frame wrap (or at once while idle). The display
// therefore never shows a torn frame.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   enable      1 = scan running, 0 = display dark
//   load        capture request for data_in / dp_in / blank_lz
//   data_in     four BCD nibbles, [3:0] = digit 0
//   dp_in       decimal-point request, bit i = digit i
//   blank_lz    leading-zero suppression request
//   busy        pending buffer full, loads are refused
//   load_ack    one-cycle pulse after an accepted load
//   bcd_out     BCD code of the active digit, 4'hF = blank
//   dp_out      decimal point of the active digit
//   dig_sel     active-low one-hot digit enables, 4'b1111 = all off
//   frame_tick  one-cycle pulse on the frame-wrap cycle
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic        busy,
    output logic        load_ack,
    output logic [3:0]  bcd_out,
    output logic        dp_out,
    output logic [3:0]  dig_sel,
    output logic        frame_tick
);

    localparam int MAXC  = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CNT_W = $clog2(MAXC);
    localparam bit HAS_GAP = (BLANK_CYC > 0);

    localparam logic [1:0]       LAST_IDX  = 2'(DIGITS - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(HAS_GAP ? BLANK_CYC - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [CNT_W-1:0] slot, slot_nxt;
    logic             wrap;

    logic [15:0] act_data, pend_data;
    logic [3:0]  act_dp, pend_dp;
    logic        act_blz, pend_blz;

    // A digit is blanked when its nibble and every more significant nibble
    // are zero; digit 0 always shows so that a value of zero still reads "0".
    function automatic logic lead_zero(input logic [15:0] d, input logic [1:0] i);
        case (i)
            2'd3:    lead_zero = (d[15:12] == 4'd0);
            2'd2:    lead_zero = (d[15:8]  == 8'd0);
            2'd1:    lead_zero = (d[15:4]  == 12'd0);
            default: lead_zero = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        next_idx = (i == LAST_IDX) ? 2'd0 : i + 2'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= 2'd0;
            slot  <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            slot  <= slot_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        slot_nxt  = slot;
        wrap      = 1'b0;
        case (state)
            IDLE: begin
                idx_nxt  = 2'd0;
                slot_nxt = '0;
                state_nxt = SHOW;
            end
            SHOW: begin
                if (slot == SHOW_LAST) begin
                    slot_nxt = '0;
                    if (HAS_GAP) begin
                        state_nxt = GAP;
                    end else begin
                        idx_nxt = next_idx(idx);
                        wrap    = (idx == LAST_IDX);
                    end
                end else begin
                    slot_nxt = slot + CNT_W'(1);
                end
            end
            GAP: begin
                if (slot == GAP_LAST) begin
                    slot_nxt  = '0;
                    state_nxt = SHOW;
                    idx_nxt   = next_idx(idx);
                    wrap      = (idx == LAST_IDX);
                end else begin
                    slot_nxt = slot + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Dropping enable aborts the scan wherever it is; an aborted wrap is
        // not a frame boundary, so no tick and no buffer swap.
        if (!enable) begin
            state_nxt = IDLE;
            idx_nxt   = 2'd0;
            slot_nxt  = '0;
            wrap      = 1'b0;
        end
    end

    assign frame_tick = wrap;

    // Buffer handshake. While busy a load is refused, including on the wrap
    // cycle itself: busy only clears at the edge that ends that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            load_ack  <= 1'b0;
            act_data  <= '0;
            act_dp    <= '0;
            act_blz   <= 1'b0;
            pend_data <= '0;
            pend_dp   <= '0;
            pend_blz  <= 1'b0;
        end else begin
            load_ack <= load && !busy;
            if (load && !busy) begin
                pend_data <= data_in;
                pend_dp   <= dp_in;
                pend_blz  <= blank_lz;
                busy      <= 1'b1;
            end else if (busy && (wrap || state == IDLE)) begin
                act_data <= pend_data;
                act_dp   <= pend_dp;
                act_blz  <= pend_blz;
                busy     <= 1'b0;
            end
        end
    end

    // Digit outputs decode straight from registered state: no extra latency.
    always_comb begin
        dig_sel = 4'b1111;
        bcd_out = 4'hF;
        dp_out  = 1'b0;
        if (state == SHOW) begin
            dig_sel[idx] = 1'b0;
            bcd_out      = act_data[{idx, 2'b00} +: 4];
            dp_out       = act_dp[idx];
            if (act_blz && lead_zero(act_data, idx)) begin
                bcd_out = 4'hF;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
//
// Scoreboard bench. The stimulus process drives one cycle at a time, derives
// the expected outputs for that cycle from a time-based model of the scan
// (elapsed clocks since the scan started, divided into slots and frames),
// and queues them. A monitor process samples the DUT on the falling edge and
// compares against the queue.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

    localparam int SCAN_DIV  = 4;
    localparam int BLANK_CYC = 1;

    logic        clk = 1'b0;
    logic        rst, enable, load, blank_lz;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        busy, load_ack, dp_out, frame_tick;
    logic [3:0]  bcd_out, dig_sel;

    display_scan_ctrl #(
        .DIGITS   (4),
        .SCAN_DIV (SCAN_DIV),
        .BLANK_CYC(BLANK_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .load      (load),
        .data_in   (data_in),
        .dp_in     (dp_in),
        .blank_lz  (blank_lz),
        .busy      (busy),
        .load_ack  (load_ack),
        .bcd_out   (bcd_out),
        .dp_out    (dp_out),
        .dig_sel   (dig_sel),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] dig;
        logic [3:0] bcd;
        logic       dp;
        logic       ft;
        logic       busy;
        logic       ack;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state (written only by the stimulus process).
    bit          m_run;
    int          m_t;
    bit          m_busy, m_ack;
    logic [15:0] m_act_d, m_pend_d;
    logic [3:0]  m_act_dp, m_pend_dp;
    bit          m_act_blz, m_pend_blz;

    task automatic model_reset();
        m_run = 0; m_t = 0; m_busy = 0; m_ack = 0;
        m_act_d = '0; m_pend_d = '0; m_act_dp = '0; m_pend_dp = '0;
        m_act_blz = 0; m_pend_blz = 0;
    endtask

    task automatic step(input bit r, input bit en, input bit ld,
                        input logic [15:0] d, input logic [3:0] dp, input bit blz);
        exp_t e;
        int   per, ph, dg;
        bit   ft;
        rst = r; enable = en; load = ld; data_in = d; dp_in = dp; blank_lz = blz;
        per = SCAN_DIV + BLANK_CYC;
        e.dig = 4'hF; e.bcd = 4'hF; e.dp = 1'b0; ft = 0;
        if (m_run) begin
            ph = m_t % per;
            dg = (m_t / per) % 4;
            if (ph < SCAN_DIV) begin
                e.dig[dg] = 1'b0;
                e.bcd     = m_act_d[4*dg +: 4];
                if (m_act_blz && dg > 0 && (m_act_d >> (4*dg)) == 16'd0) e.bcd = 4'hF;
                e.dp = m_act_dp[dg];
            end
            ft = en && (ph == per - 1) && (dg == 3);
        end
        e.ft = ft; e.busy = m_busy; e.ack = m_ack;
        q.push_back(e);

        if (r) begin
            model_reset();
        end else begin
            m_ack = ld && !m_busy;
            if (ld && !m_busy) begin
                m_pend_d = d; m_pend_dp = dp; m_pend_blz = blz; m_busy = 1;
            end else if (m_busy && (ft || !m_run)) begin
                m_act_d = m_pend_d; m_act_dp = m_pend_dp; m_act_blz = m_pend_blz; m_busy = 0;
            end
            if (!en) begin
                m_run = 0; m_t = 0;
            end else if (!m_run) begin
                m_run = 1; m_t = 0;
            end else begin
                m_t++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input bit en);
        for (int i = 0; i < n; i++) step(0, en, 0, 16'h0, 4'h0, 0);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("dig_sel",    int'(dig_sel),    int'(e.dig));
                chk("bcd_out",    int'(bcd_out),    int'(e.bcd));
                chk("dp_out",     int'(dp_out),     int'(e.dp));
                chk("frame_tick", int'(frame_tick), int'(e.ft));
                chk("busy",       int'(busy),       int'(e.busy));
                chk("load_ack",   int'(load_ack),   int'(e.ack));
            end
        end
    end

    function automatic logic [15:0] rand_data();
        logic [15:0] v;
        for (int k = 0; k < 4; k++)
            v[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        return v;
    endfunction

    initial begin : stim
        rst = 1'b1; enable = 1'b0; load = 1'b0;
        data_in = '0; dp_in = '0; blank_lz = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        // Reset state, then 1234 loaded while idle and scanned.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 16'h0, 4'h0, 0);
        step(0, 0, 1, 16'h1234, 4'h0, 0);
        run(2, 0);
        run(45, 1);

        // Mid-frame load with suppression, then loads refused while busy.
        step(0, 1, 1, 16'h0042, 4'h0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 16'h9999, 4'hF, 0);
        run(45, 1);

        // Accepted load, then load held high across the frame boundary.
        step(0, 1, 1, 16'h5678, 4'h1, 0);
        for (int i = 0; i < 25; i++) step(0, 1, 1, 16'h1111, 4'h8, 0);
        run(45, 1);

        // All-zero value with suppression and a decimal point on digit 2.
        step(0, 1, 1, 16'h0000, 4'b0100, 1);
        run(45, 1);

        // Enable dropped in the middle of digit 2, then restarted.
        run(3, 0);
        run(13, 1);
        run(2, 0);
        run(25, 1);

        // Reset mid-SHOW coincident with a load.
        run(6, 1);
        step(1, 1, 1, 16'hABCD, 4'hF, 1);
        run(25, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 149) != 0),
                 ($urandom_range(0, 19) == 0),
                 rand_data(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
